// File: rtl/pin_link_tx.sv
`default_nettype none
// ============================================================================
// Module      : pin_link_tx
// Description : Transmit end of a byte-wide four-phase req/ack pin link with
//               a small input FIFO, programmable data setup delay and a
//               sticky per-edge acknowledge timeout.
// Revision    : 1.0
// ============================================================================
module pin_link_tx #(
    parameter int DEPTH       = 4,
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [7:0]             link_data,
    output logic                   link_req,
    input  logic                   link_ack,
    output logic                   busy,
    output logic                   err_timeout,
    input  logic                   err_clr,
    output logic [$clog2(DEPTH):0] level
);

    localparam int          AW           = $clog2(DEPTH);
    localparam logic [AW:0] C_PTR_ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [3:0]  C_SETUP_LOAD = 4'(SETUP_CYC - 1);
    localparam logic [15:0] C_TO_LAST    = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] C_TO_MAX     = 16'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SETUP   = 3'd2,
        S_WAIT_HI = 3'd3,
        S_WAIT_LO = 3'd4
    } state_t;

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        ack_meta_q;
    logic        ack_s_q;

    state_t      state_q,     state_d;
    logic [3:0]  setup_cnt_q, setup_cnt_d;
    logic [15:0] to_cnt_q,    to_cnt_d;
    logic        req_q,       req_d;
    logic [7:0]  data_q,      data_d;
    logic        err_q,       err_d;

    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        to_hit;
    logic [15:0] to_cnt_inc;

    // ------------------------------------------------------------------
    // FIFO: one extra pointer bit distinguishes full from empty
    // ------------------------------------------------------------------
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = s_valid && !full;
    assign pop   = (state_q == S_LOAD);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
            end
        end
    end

    // The far end is asynchronous; two flops before ack is ever looked at.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= link_ack;
            ack_s_q    <= ack_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    assign to_hit     = (to_cnt_q >= C_TO_LAST);
    assign to_cnt_inc = (to_cnt_q == C_TO_MAX) ? to_cnt_q : to_cnt_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        to_cnt_d    = to_cnt_q;
        req_d       = req_q;
        data_d      = data_q;
        err_d       = err_q;

        // Clear first so that a timeout in the same cycle overrides it.
        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                req_d = 1'b0;
                if (!empty) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                data_d      = mem_q[rd_ptr_q[AW-1:0]];
                setup_cnt_d = C_SETUP_LOAD;
                state_d     = S_SETUP;
            end

            S_SETUP: begin
                if (setup_cnt_q == 4'd0) begin
                    req_d    = 1'b1;
                    to_cnt_d = 16'd0;
                    state_d  = S_WAIT_HI;
                end else begin
                    setup_cnt_d = setup_cnt_q - 4'd1;
                end
            end

            S_WAIT_HI: begin
                if (ack_s_q) begin
                    req_d    = 1'b0;
                    to_cnt_d = 16'd0;
                    state_d  = S_WAIT_LO;
                end else if (to_hit) begin
                    err_d    = 1'b1;
                    req_d    = 1'b0;
                    to_cnt_d = to_cnt_inc;
                    state_d  = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_inc;
                end
            end

            S_WAIT_LO: begin
                // Skip IDLE when more data is queued to keep the link streaming.
                if (!ack_s_q) begin
                    state_d = empty ? S_IDLE : S_LOAD;
                end else if (to_hit) begin
                    err_d    = 1'b1;
                    to_cnt_d = to_cnt_inc;
                    state_d  = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_inc;
                end
            end

            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            setup_cnt_q <= 4'd0;
            to_cnt_q    <= 16'd0;
            req_q       <= 1'b0;
            data_q      <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            setup_cnt_q <= setup_cnt_d;
            to_cnt_q    <= to_cnt_d;
            req_q       <= req_d;
            data_q      <= data_d;
            err_q       <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_ready     = !full;
    assign link_data   = data_q;
    assign link_req    = req_q;
    assign err_timeout = err_q;
    assign busy        = !empty || (state_q != S_IDLE);
    assign level       = wr_ptr_q - rd_ptr_q;

endmodule
`default_nettype wire
